// File: rtl/pio_evt_pkg.sv
// pio_evt_pkg: shared state encoding, PIO register map and event record for the PIO edge-event sequencer
package pio_evt_pkg;
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_CAP  = 2'd3;
  localparam int PIO_W    = 26;
  localparam int PIO_TS_W = 32;
  typedef enum logic [2:0] {
    ST_INIT_MASK,
    ST_CLR_INIT,
    ST_IDLE,
    ST_RD_CAP,
    ST_CLR_CAP,
    ST_RD_DATA,
    ST_PUSH
  } state_t;
  typedef struct packed {
    logic [PIO_W-1:0]    capture;
    logic [PIO_W-1:0]    data;
    logic [PIO_TS_W-1:0] ts;
  } evt_t;
endpackage

// File: rtl/pio_evt_fifo.sv
// pio_evt_fifo: synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle
module pio_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_pop, w_push;
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_dout  = r_mem[r_rp];
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // storage write, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end
endmodule

// File: rtl/pio_edge_event_sequencer.sv
// pio_edge_event_sequencer: Avalon-MM master servicing an edge-capture PIO into an event FIFO; PIO_EVT_TIMESTAMP_EN adds timestamps
module pio_edge_event_sequencer
  import pio_evt_pkg::*;
#(
  parameter int W     = 26,
  parameter int DEPTH = 8,
  parameter int TS_W  = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [W-1:0]    irq_mask_cfg,
  input  logic            irq_in,
  output logic [1:0]      avm_address,
  output logic            avm_chipselect,
  output logic            avm_write_n,
  output logic [31:0]     avm_writedata,
  input  logic [31:0]     avm_readdata,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [W-1:0]    evt_capture,
  output logic [W-1:0]    evt_data,
  output logic [TS_W-1:0] evt_timestamp,
  output logic [15:0]     overflow_cnt,
  output logic            busy
);
`ifdef PIO_EVT_TIMESTAMP_EN
  localparam int FW = 2*W + TS_W;
`else
  localparam int FW = 2*W;
`endif
  state_t        r_state;
  logic [W-1:0]  r_mask_shadow, r_cap;
  logic [15:0]   r_ovf;
  logic          w_wr, w_rd, w_push, w_full, w_empty, w_pop, w_unused_rd;
  logic [FW-1:0] w_din, w_dout;
  assign w_unused_rd = ^avm_readdata[31:W];
  assign w_push      = r_state == ST_PUSH;
  assign w_pop       = evt_ready & ~w_empty;
  assign evt_valid   = ~w_empty;
  assign overflow_cnt = r_ovf;
  assign busy        = r_state != ST_IDLE;
  assign evt_capture = w_dout[FW-1 -: W];
  assign evt_data    = w_dout[FW-W-1 -: W];
`ifdef PIO_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts_cnt, r_ts;
  logic            w_take;
  assign w_take        = r_state == ST_IDLE && irq_mask_cfg == r_mask_shadow && enable && irq_in;
  assign w_din         = {r_cap, avm_readdata[W-1:0], r_ts};
  assign evt_timestamp = w_dout[TS_W-1:0];
  // free-running timestamp; snapshot taken when an irq is accepted
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ts_cnt <= '0;
      r_ts     <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 1'b1;
      if (w_take) r_ts <= r_ts_cnt;
    end
  end
`else
  assign w_din         = {r_cap, avm_readdata[W-1:0]};
  assign evt_timestamp = '0;
`endif
  // bus strobes decoded from state; held inactive while reset is asserted
  always_comb begin
    w_wr           = reset_n && (r_state == ST_INIT_MASK || r_state == ST_CLR_INIT || r_state == ST_CLR_CAP);
    w_rd           = reset_n && (r_state == ST_RD_CAP || r_state == ST_RD_DATA);
    avm_chipselect = w_wr | w_rd;
    avm_write_n    = ~w_wr;
    avm_address    = !(w_wr | w_rd) ? 2'd0 :
                     r_state == ST_INIT_MASK ? PIO_ADDR_MASK :
                     r_state == ST_RD_DATA ? PIO_ADDR_DATA : PIO_ADDR_CAP;
    avm_writedata  = !w_wr ? 32'h0 :
                     r_state == ST_INIT_MASK ? 32'(irq_mask_cfg) : 32'hFFFF_FFFF;
  end
  // service sequencer: program mask, then per irq read capture, clear it, read port
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_INIT_MASK;
      r_mask_shadow <= '0;
      r_cap         <= '0;
    end else begin
      case (r_state)
        ST_INIT_MASK: begin
          r_mask_shadow <= irq_mask_cfg;
          r_state       <= ST_CLR_INIT;
        end
        ST_CLR_INIT: r_state <= ST_IDLE;
        ST_IDLE:     r_state <= irq_mask_cfg != r_mask_shadow ? ST_INIT_MASK :
                                (enable && irq_in) ? ST_RD_CAP : ST_IDLE;
        ST_RD_CAP:   r_state <= ST_CLR_CAP;
        ST_CLR_CAP: begin
          r_cap   <= avm_readdata[W-1:0];
          r_state <= avm_readdata[W-1:0] == '0 ? ST_IDLE : ST_RD_DATA;
        end
        ST_RD_DATA:  r_state <= ST_PUSH;
        ST_PUSH:     r_state <= ST_IDLE;
        default:     r_state <= ST_INIT_MASK;
      endcase
    end
  end
  // dropped-event counter, saturating
  always_ff @(posedge clk) begin
    if (!reset_n) r_ovf <= '0;
    else if (w_push && w_full && !w_pop && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 1'b1;
  end
  pio_evt_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule

// File: tb/tb_pio_edge_event_sequencer.sv
// tb_pio_edge_event_sequencer: directed bench with a PIO slave model and an event-queue reference model
module tb_pio_edge_event_sequencer;
  localparam int W = 26, DEPTH = 8, TS_W = 32;
  logic clk = 0, reset_n = 0, enable = 1, evt_ready = 0, force_irq = 0, irq_in;
  logic [W-1:0] irq_mask_cfg = 26'h3, port = '0;
  logic [1:0] avm_address;
  logic avm_chipselect, avm_write_n, evt_valid, busy;
  logic [31:0] avm_writedata, avm_readdata;
  logic [W-1:0] evt_capture, evt_data;
  logic [TS_W-1:0] evt_timestamp;
  logic [15:0] overflow_cnt;
  int n_chk = 0, n_fail = 0;

  pio_edge_event_sequencer #(.W(W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .irq_mask_cfg(irq_mask_cfg), .irq_in(irq_in),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_capture(evt_capture), .evt_data(evt_data),
    .evt_timestamp(evt_timestamp), .overflow_cnt(overflow_cnt), .busy(busy));

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // PIO slave: edge capture with clear-all on write, registered readdata
  logic [W-1:0] p_mask = '0, p_cap = '0, p_prev = '0;
  logic [31:0]  p_rd = '0;
  assign irq_in = (|(p_cap & p_mask)) | force_irq;
  assign avm_readdata = p_rd;
  always @(posedge clk) begin
    p_prev <= port;
    if (avm_chipselect && !avm_write_n && avm_address == 2'd3) p_cap <= '0;
    else p_cap <= p_cap | (port & ~p_prev);
    if (avm_chipselect && !avm_write_n && avm_address == 2'd2) p_mask <= avm_writedata[W-1:0];
    p_rd <= !(avm_chipselect && avm_write_n) ? 32'h0 :
            avm_address == 2'd0 ? 32'(port) :
            avm_address == 2'd2 ? 32'(p_mask) :
            avm_address == 2'd3 ? 32'(p_cap) : 32'h0;
  end

  // reference model: events the PIO handed out, bounded queue, saturating drop count
  typedef struct {logic [W-1:0] c; logic [W-1:0] d; logic [TS_W-1:0] t;} ev_t;
  ev_t q[$];
  ev_t m_ev;
  int m_ovf = 0;
  bit m_pend = 0;
  logic [TS_W-1:0] cyc = '0;
  always @(posedge clk) begin
    if (!reset_n) begin
      q.delete();
      m_ovf  = 0;
      m_pend = 0;
      cyc    = '0;
    end else begin
      if (evt_ready && q.size() > 0) void'(q.pop_front());
      if (m_pend) begin
        if (q.size() < DEPTH) q.push_back(m_ev);
        else if (m_ovf < 65535) m_ovf++;
        m_pend = 0;
      end
      if (avm_chipselect && avm_write_n && avm_address == 2'd3) begin
        m_ev.c = p_cap;
`ifdef PIO_EVT_TIMESTAMP_EN
        m_ev.t = cyc - 1'b1;
`else
        m_ev.t = '0;
`endif
      end
      if (avm_chipselect && avm_write_n && avm_address == 2'd0 && m_ev.c != '0) begin
        m_ev.d = port;
        m_pend = 1;
      end
      cyc = cyc + 1'b1;
    end
  end

  // per-cycle comparison of the event stream against the model
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("m_evt_valid", evt_valid, q.size() > 0);
      chk("m_overflow_cnt", overflow_cnt, m_ovf);
      if (q.size() > 0) begin
        chk("m_evt_capture", evt_capture, q[0].c);
        chk("m_evt_data", evt_data, q[0].d);
        chk("m_evt_timestamp", evt_timestamp, q[0].t);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, wi, ri;
    bit seen;
    logic [TS_W-1:0] prev_ts;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_write_n", avm_write_n, 1);
    chk("rst_addr", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_ovf", overflow_cnt, 0);
    chk("rst_busy", busy, 1);
    reset_n = 1;
    #1;
    chk("init_cs", avm_chipselect, 1);
    chk("init_write_n", avm_write_n, 0);
    chk("init_addr", avm_address, 2);
    chk("init_wdata", avm_writedata, 32'h3);
    @(negedge clk);
    chk("clrinit_write", {avm_chipselect, avm_write_n, avm_address}, {2'b10, 2'd3});
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_cs", avm_chipselect, 0);
    chk("pio_mask_3", p_mask, 26'h3);

    irq_mask_cfg = 26'h3FF_FFFF;
    repeat (4) @(negedge clk);
    chk("pio_mask_all", p_mask, 26'h3FF_FFFF);
    chk("remask_idle", busy, 0);
    port = 26'h20;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      seen = irq_in;
    end
    chk("irq_seen", seen, 1);
    n = 0;
    while (!evt_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("evt_latency", n, 5);
    chk("evt_cap_20", evt_capture, 26'h20);
    chk("evt_data_20", evt_data, 26'h20);
`ifdef PIO_EVT_TIMESTAMP_EN
    chk("evt_ts_nonzero", evt_timestamp != '0, 1);
`else
    chk("evt_ts_zero", evt_timestamp, 0);
`endif
    evt_ready = 1;
    @(negedge clk);
    evt_ready = 0;
    chk("evt_popped", evt_valid, 0);
    port = '0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      port = W'((i << 8) | 1);
      repeat (8) @(negedge clk);
      port = '0;
      @(negedge clk);
    end
    chk("ovf_one", overflow_cnt, 1);
    chk("full_valid", evt_valid, 1);
    evt_ready = 1;
    prev_ts = '0;
    for (int j = 0; j < DEPTH; j++) begin
      chk("drain_cap", evt_capture, W'((j << 8) | 1));
      chk("drain_data", evt_data, W'((j << 8) | 1));
`ifdef PIO_EVT_TIMESTAMP_EN
      if (j > 0) chk("drain_ts_incr", evt_timestamp > prev_ts, 1);
      prev_ts = evt_timestamp;
`endif
      @(negedge clk);
    end
    evt_ready = 0;
    chk("drained", evt_valid, 0);

    irq_mask_cfg = 26'h1;
    force_irq = 1;
    wi = -1;
    ri = -1;
    for (int k = 1; k <= 12 && ri < 0; k++) begin
      @(negedge clk);
      if (avm_chipselect && !avm_write_n && avm_address == 2'd2 && wi < 0) wi = k;
      if (avm_chipselect && avm_write_n && avm_address == 2'd3) begin
        ri = k;
        force_irq = 0;
      end
    end
    force_irq = 0;
    chk("mask_write_first", wi, 1);
    chk("rdcap_after_mask", ri, 4);
    @(negedge clk);
    chk("spur_clear_write", {avm_chipselect, avm_write_n, avm_address}, {2'b10, 2'd3});
    chk("spur_clear_data", avm_writedata, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("spur_idle", busy, 0);
    chk("spur_no_push", evt_valid, 0);
    chk("pio_mask_1", p_mask, 26'h1);

    port = 26'h1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = avm_chipselect && avm_write_n && avm_address == 2'd0;
    end
    chk("rd_data_seen", seen, 1);
    reset_n = 0;
    #1;
    chk("rst_mid_cs", avm_chipselect, 0);
    @(negedge clk);
    reset_n = 1;
    #1;
    chk("restart_init", {avm_chipselect, avm_write_n, avm_address}, {2'b10, 2'd2});
    chk("restart_wdata", avm_writedata, 32'h1);
    repeat (10) @(negedge clk);
    chk("restart_no_evt", evt_valid, 0);
    chk("restart_idle", busy, 0);
    chk("restart_ovf", overflow_cnt, 0);
    port = '0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
